// File: rtl/ram_dual_arb.sv
// Two-requester arbiter in front of a dual-port RAM.
// Writes compete for the RAM write port and reads for the read port, each
// with its own round-robin pointer. A write and a read to the same address
// in the same cycle issue the write only; the read waits one cycle so it
// returns the new data. Read data is steered back to the requester that
// issued the read, one cycle after its grant.
module ram_dual_arb #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 32,
    parameter int ADDRESS = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_a_req,
    input  logic               i_a_we,
    input  logic [ADDRESS-1:0] i_a_addr,
    input  logic [WIDTH-1:0]   i_a_wdata,
    output logic               o_a_gnt,
    output logic               o_a_rvalid,
    output logic [WIDTH-1:0]   o_a_rdata,
    input  logic               i_b_req,
    input  logic               i_b_we,
    input  logic [ADDRESS-1:0] i_b_addr,
    input  logic [WIDTH-1:0]   i_b_wdata,
    output logic               o_b_gnt,
    output logic               o_b_rvalid,
    output logic [WIDTH-1:0]   o_b_rdata,
    output logic               o_ram_cs,
    output logic               o_ram_valid,
    output logic               o_ram_wr_en,
    output logic [ADDRESS-1:0] o_ram_wr_addr,
    output logic [WIDTH-1:0]   o_ram_wr_data,
    output logic               o_ram_rd_en,
    output logic [ADDRESS-1:0] o_ram_rd_addr,
    input  logic [WIDTH-1:0]   i_ram_rd_data,
    input  logic               i_ram_ready
);

    // The address bus must cover the RAM exactly.
    if (ADDRESS != $clog2(DEPTH)) begin : g_bad_address
        $error("ram_dual_arb: ADDRESS must equal clog2(DEPTH)");
    end

    // Round-robin pointers: 0 favours A, 1 favours B.
    logic wr_prio;
    logic rd_prio;

    // Read owner, one cycle behind the read grant.
    logic vld_a_p1;
    logic vld_b_p1;

    // Request decode and arbitration (stage p0, combinational).
    logic en_p0;
    logic wr_a_p0, wr_b_p0, rd_a_p0, rd_b_p0;
    logic wr_sel_a_p0, wr_sel_b_p0, rd_sel_a_p0, rd_sel_b_p0;
    logic hazard_p0;
    logic wr_gnt_a_p0, wr_gnt_b_p0, rd_gnt_a_p0, rd_gnt_b_p0;
    logic [ADDRESS-1:0] wr_addr_p0, rd_addr_p0;

    // Holding reset also blocks grants so every output is quiet during reset.
    assign en_p0   = i_ram_ready & i_rst_n;

    assign wr_a_p0 = i_a_req &  i_a_we;
    assign wr_b_p0 = i_b_req &  i_b_we;
    assign rd_a_p0 = i_a_req & ~i_a_we;
    assign rd_b_p0 = i_b_req & ~i_b_we;

    assign wr_sel_a_p0 = wr_a_p0 & (~wr_b_p0 | ~wr_prio);
    assign wr_sel_b_p0 = wr_b_p0 & (~wr_a_p0 |  wr_prio);
    assign rd_sel_a_p0 = rd_a_p0 & (~rd_b_p0 | ~rd_prio);
    assign rd_sel_b_p0 = rd_b_p0 & (~rd_a_p0 |  rd_prio);

    // A selected write and a selected read can only come from different
    // requesters, so comparing the two winners' addresses is enough.
    assign wr_addr_p0 = wr_sel_a_p0 ? i_a_addr : i_b_addr;
    assign rd_addr_p0 = rd_sel_a_p0 ? i_a_addr : i_b_addr;
    assign hazard_p0  = (wr_sel_a_p0 | wr_sel_b_p0) & (rd_sel_a_p0 | rd_sel_b_p0)
                      & (wr_addr_p0 == rd_addr_p0);

    assign wr_gnt_a_p0 = en_p0 & wr_sel_a_p0;
    assign wr_gnt_b_p0 = en_p0 & wr_sel_b_p0;
    assign rd_gnt_a_p0 = en_p0 & rd_sel_a_p0 & ~hazard_p0;
    assign rd_gnt_b_p0 = en_p0 & rd_sel_b_p0 & ~hazard_p0;

    // Flip each pointer only when both sides contended for that port and one was granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_prio <= 1'b0;
            rd_prio <= 1'b0;
        end else begin
            if (en_p0 && wr_a_p0 && wr_b_p0) begin
                wr_prio <= ~wr_prio;
            end
            if (en_p0 && rd_a_p0 && rd_b_p0) begin
                rd_prio <= ~rd_prio;
            end
        end
    end

    // Stage p0 -> p1: remember who owns the read data arriving next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
        end else begin
            vld_a_p1 <= rd_gnt_a_p0;
            vld_b_p1 <= rd_gnt_b_p0;
        end
    end

    // Drive RAM strobes, grants and returned read data; idle buses stay at zero.
    always_comb begin
        o_ram_wr_en   = wr_gnt_a_p0 | wr_gnt_b_p0;
        o_ram_valid   = wr_gnt_a_p0 | wr_gnt_b_p0;
        o_ram_rd_en   = rd_gnt_a_p0 | rd_gnt_b_p0;
        o_ram_cs      = o_ram_wr_en | o_ram_rd_en;
        o_ram_wr_addr = '0;
        o_ram_wr_data = '0;
        o_ram_rd_addr = '0;
        if (wr_gnt_a_p0) begin
            o_ram_wr_addr = i_a_addr;
            o_ram_wr_data = i_a_wdata;
        end else if (wr_gnt_b_p0) begin
            o_ram_wr_addr = i_b_addr;
            o_ram_wr_data = i_b_wdata;
        end
        if (rd_gnt_a_p0) begin
            o_ram_rd_addr = i_a_addr;
        end else if (rd_gnt_b_p0) begin
            o_ram_rd_addr = i_b_addr;
        end
        o_a_gnt    = wr_gnt_a_p0 | rd_gnt_a_p0;
        o_b_gnt    = wr_gnt_b_p0 | rd_gnt_b_p0;
        o_a_rvalid = vld_a_p1;
        o_b_rvalid = vld_b_p1;
        o_a_rdata  = vld_a_p1 ? i_ram_rd_data : '0;
        o_b_rdata  = vld_b_p1 ? i_ram_rd_data : '0;
    end

endmodule

// File: tb/tb_ram_dual_arb.sv
// Bench for ram_dual_arb: a small behavioural RAM behind the arbiter,
// a table of per-cycle vectors, and a hand sequence around reset.
module tb_ram_dual_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        ram_cs, ram_valid, ram_wr_en, ram_rd_en;
    logic [4:0]  ram_wr_addr, ram_rd_addr;
    logic [15:0] ram_wr_data, ram_rd_data;
    logic        ram_ready;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ram_dual_arb #(.WIDTH(16), .DEPTH(32), .ADDRESS(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
        .o_ram_cs(ram_cs), .o_ram_valid(ram_valid), .o_ram_wr_en(ram_wr_en),
        .o_ram_wr_addr(ram_wr_addr), .o_ram_wr_data(ram_wr_data),
        .o_ram_rd_en(ram_rd_en), .o_ram_rd_addr(ram_rd_addr),
        .i_ram_rd_data(ram_rd_data), .i_ram_ready(ram_ready)
    );

    // Behavioural dual-port RAM with a registered read.
    logic [15:0] mem [0:31];
    always @(posedge clk) begin
        if (ram_cs && ram_wr_en && ram_valid) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_cs && ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    typedef struct {
        logic        ra, wa;
        logic [4:0]  aa;
        logic [15:0] da;
        logic        rb, wb;
        logic [4:0]  ab;
        logic [15:0] db;
        logic        rdy;
        logic        ga, gb, rva, rvb;
        logic [15:0] rda, rdb;
        logic        ewe, ere;
        logic [4:0]  ewa;
        logic [15:0] ewd;
        logic [4:0]  era;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ra, input logic wa, input logic [4:0] aa, input logic [15:0] da,
                       input logic rb, input logic wb, input logic [4:0] ab, input logic [15:0] db,
                       input logic rdy,
                       input logic ga, input logic gb, input logic rva, input logic rvb,
                       input logic [15:0] rda, input logic [15:0] rdb,
                       input logic ewe, input logic ere, input logic [4:0] ewa,
                       input logic [15:0] ewd, input logic [4:0] era);
        vec_t v;
        v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
        v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
        v.rdy = rdy;
        v.ga = ga; v.gb = gb; v.rva = rva; v.rvb = rvb; v.rda = rda; v.rdb = rdb;
        v.ewe = ewe; v.ere = ere; v.ewa = ewa; v.ewd = ewd; v.era = era;
        vq.push_back(v);
    endtask

    // All outputs as one word: gnt a/b, rvalid a/b, rdata a/b, cs, wr_en, rd_en, valid, wr addr/data, rd addr.
    function automatic logic [65:0] outs();
        return {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
                ram_cs, ram_wr_en, ram_rd_en, ram_valid,
                ram_wr_addr, ram_wr_data, ram_rd_addr};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic drive(input logic ra, input logic wa, input logic [4:0] aa, input logic [15:0] da,
                         input logic rb, input logic wb, input logic [4:0] ab, input logic [15:0] db);
        a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
        b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
    endtask

    initial begin
        rst_n = 1'b0;
        ram_ready = 1'b1;
        drive(1, 1, 5'd4, 16'h4444, 1, 0, 5'd4, 16'h0);

        // Reset state: requests present but nothing granted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 66'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // idle
        add(0,0,0,0,       0,0,0,0,       1, 0,0,0,0,0,0,             0,0,0,0,0);
        // A write 3, A read 3, data back
        add(1,1,3,'h0042,  0,0,0,0,       1, 1,0,0,0,0,0,             1,0,3,'h0042,0);
        add(1,0,3,0,       0,0,0,0,       1, 1,0,0,0,0,0,             0,1,0,0,3);
        add(0,0,0,0,       0,0,0,0,       1, 0,0,1,0,'h0042,0,        0,0,0,0,0);
        // contended writes: A,B,A,B
        add(1,1,0,'hA000,  1,1,1,'hB001,  1, 1,0,0,0,0,0,             1,0,0,'hA000,0);
        add(1,1,2,'hA002,  1,1,1,'hB001,  1, 0,1,0,0,0,0,             1,0,1,'hB001,0);
        add(1,1,2,'hA002,  1,1,3,'hB003,  1, 1,0,0,0,0,0,             1,0,2,'hA002,0);
        add(1,1,2,'hA002,  1,1,3,'hB003,  1, 0,1,0,0,0,0,             1,0,3,'hB003,0);
        // back-to-back reads by A of 0..3
        add(1,0,0,0,       0,0,0,0,       1, 1,0,0,0,0,0,             0,1,0,0,0);
        add(1,0,1,0,       0,0,0,0,       1, 1,0,1,0,'hA000,0,        0,1,0,0,1);
        add(1,0,2,0,       0,0,0,0,       1, 1,0,1,0,'hB001,0,        0,1,0,0,2);
        add(1,0,3,0,       0,0,0,0,       1, 1,0,1,0,'hA002,0,        0,1,0,0,3);
        add(0,0,0,0,       0,0,0,0,       1, 0,0,1,0,'hB003,0,        0,0,0,0,0);
        // contended reads: A first, then B; rdata routed to owner
        add(1,0,0,0,       1,0,1,0,       1, 1,0,0,0,0,0,             0,1,0,0,0);
        add(1,0,2,0,       1,0,1,0,       1, 0,1,1,0,'hA000,0,        0,1,0,0,1);
        add(1,0,2,0,       0,0,0,0,       1, 1,0,0,1,0,'hB001,        0,1,0,0,2);
        add(0,0,0,0,       0,0,0,0,       1, 0,0,1,0,'hA002,0,        0,0,0,0,0);
        // hazard: A write 5, B read 5
        add(1,1,5,'h1111,  1,0,5,0,       1, 1,0,0,0,0,0,             1,0,5,'h1111,0);
        add(0,0,0,0,       1,0,5,0,       1, 0,1,0,0,0,0,             0,1,0,0,5);
        add(0,0,0,0,       0,0,0,0,       1, 0,0,0,1,0,'h1111,        0,0,0,0,0);
        // write and read at different addresses in one cycle
        add(1,1,1,'h0001,  0,0,0,0,       1, 1,0,0,0,0,0,             1,0,1,'h0001,0);
        add(1,0,1,0,       1,1,2,'hBEEF,  1, 1,1,0,0,0,0,             1,1,2,'hBEEF,1);
        add(0,0,0,0,       1,0,2,0,       1, 0,1,1,0,'h0001,0,        0,1,0,0,2);
        add(0,0,0,0,       0,0,0,0,       1, 0,0,0,1,0,'hBEEF,        0,0,0,0,0);
        // RAM not ready: nothing moves; then A first
        add(1,1,6,'h0606,  1,1,7,'h0707,  0, 0,0,0,0,0,0,             0,0,0,0,0);
        add(1,1,6,'h0606,  1,1,7,'h0707,  0, 0,0,0,0,0,0,             0,0,0,0,0);
        add(1,1,6,'h0606,  1,1,7,'h0707,  0, 0,0,0,0,0,0,             0,0,0,0,0);
        add(1,1,6,'h0606,  1,1,7,'h0707,  1, 1,0,0,0,0,0,             1,0,6,'h0606,0);
        add(0,0,0,0,       1,1,7,'h0707,  1, 0,1,0,0,0,0,             1,0,7,'h0707,0);

        foreach (vq[i]) begin
            vec_t v;
            string nm;
            v = vq[i];
            drive(v.ra, v.wa, v.aa, v.da, v.rb, v.wb, v.ab, v.db);
            ram_ready = v.rdy;
            @(negedge clk);
            nm = $sformatf("vec%0d", i);
            check(nm, outs(),
                  {v.ga, v.gb, v.rva, v.rvb, v.rda, v.rdb,
                   v.ewe | v.ere, v.ewe, v.ere, v.ewe, v.ewa, v.ewd, v.era});
            @(posedge clk); #1;
        end

        // Reset in the cycle after a B read grant; write pointer currently favours B.
        drive(0, 0, 0, 0, 1, 0, 5'd7, 0);
        ram_ready = 1'b1;
        @(negedge clk);
        check("b_read_gnt", {62'd0, a_gnt, b_gnt, ram_rd_en, ram_cs},
              {62'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1, 1, 5'd8, 16'h0808, 1, 1, 5'd9, 16'h0909);
        #1;
        check("reset_async_clear", outs(), 66'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("in_reset%0d", k), outs(), 66'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_a_first", {46'd0, a_gnt, b_gnt, b_rvalid, ram_wr_en, ram_wr_addr, ram_wr_data},
              {46'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 16'h0808});
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 1, 5'd9, 16'h0909);
        @(negedge clk);
        check("post_reset_b_next", {46'd0, a_gnt, b_gnt, b_rvalid, ram_wr_en, ram_wr_addr, ram_wr_data},
              {46'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 16'h0909});
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("final_idle", outs(), 66'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
